// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin N:1 ready/valid arbiter
// feeding a single-entry output register.
module rv_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [ID_WIDTH-1:0]           out_id,
   input  logic                          out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [ID_WIDTH-1:0]     rr_ptr;
   logic [ID_WIDTH-1:0]     ptr_nxt;
   logic [ID_WIDTH-1:0]     win;
   logic [ID_WIDTH-1:0]     off;
   logic [ID_WIDTH:0]       sum;
   logic [2*NUM_REQ-1:0]    dbl;
   logic [NUM_REQ-1:0]      rot;
   logic [DATA_WIDTH-1:0]   win_data;
   logic                    any_req;
   logic                    capture;

   assign any_req = |req_valid;

   // Rotate so bit 0 is rr_ptr; the lowest set bit is the winner offset.
   assign dbl = {req_valid, req_valid} >> rr_ptr;
   assign rot = dbl[NUM_REQ-1:0];

   always_comb begin
      off = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (rot[k]) off = ID_WIDTH'(k);
      end
   end

   always_comb begin
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (ID_WIDTH+1)'(NUM_REQ))
         sum = sum - (ID_WIDTH+1)'(NUM_REQ);
      win = sum[ID_WIDTH-1:0];
   end

   assign ptr_nxt = (win == ID_WIDTH'(NUM_REQ-1)) ? '0 : win + 1'b1;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == ID_WIDTH'(i))
            win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         EMPTY: begin
            if (any_req) begin
               capture   = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // No capture can happen in reset, so no beat may be acknowledged.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = reset_n && capture && (win == ID_WIDTH'(i));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr   <= '0;
         out_data <= '0;
         out_id   <= '0;
      end else if (capture) begin
         rr_ptr   <= ptr_nxt;
         out_data <= win_data;
         out_id   <= win;
      end
   end

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// tb_rv_rr_arbiter: directed and random checks of rv_rr_arbiter
// against a queue-based round-robin reference model.
module tb_rv_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    req_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic [IW-1:0]    out_id;
   logic             out_ready = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   bit       m_full;
   int       m_ptr;
   int       m_id;
   int       m_data;
   int       sb_id[$];
   int       sb_dat[$];
   int       q_ids[$];
   int       q_dat[$];
   int       waitc[NR];
   int       max_wait;
   int       rdy_cyc;
   int       ov_cyc;

   rv_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (p + k) % NR;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_data = 0;
      sb_id.delete();
      sb_dat.delete();
      for (int i = 0; i < NR; i++) waitc[i] = 0;
   endtask

   task automatic clr_stats();
      q_ids.delete();
      q_dat.delete();
      rdy_cyc = 0;
      ov_cyc  = 0;
   endtask

   task automatic tick();
      int g;
      int e_rdy;
      @(negedge clk);
      g = pick(req_valid, m_ptr);
      e_rdy = (!m_full && g >= 0) ? (1 << g) : 0;
      check("req_ready", 32'(req_ready), 32'(e_rdy));
      check("out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
         check("out_id", 32'(out_id), 32'(m_id));
         check("out_data", 32'(out_data), 32'(m_data));
      end
      if (req_ready != '0) rdy_cyc++;
      if (out_valid) ov_cyc++;
      if (out_valid && out_ready) begin
         q_ids.push_back(int'(out_id));
         q_dat.push_back(int'(out_data));
         if (sb_id.size() == 0) begin
            check("sb_dup", 32'(out_id), 32'hFFFF_FFFF);
         end else begin
            check("sb_id", 32'(out_id), 32'(sb_id.pop_front()));
            check("sb_data", 32'(out_data), 32'(sb_dat.pop_front()));
         end
      end
      if (!m_full) begin
         if (g >= 0) begin
            m_id   = g;
            m_data = int'(8'(req_data >> (g * DW)));
            m_ptr  = (g + 1) % NR;
            m_full = 1'b1;
            sb_id.push_back(m_id);
            sb_dat.push_back(m_data);
            for (int i = 0; i < NR; i++) begin
               if (i == g) waitc[i] = 0;
               else if (req_valid[i]) waitc[i]++;
               else waitc[i] = 0;
               if (waitc[i] > max_wait) max_wait = waitc[i];
            end
         end
      end else if (out_ready) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_id", 32'(out_id), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      #1;
      model_reset();
   endtask

   initial begin
      max_wait = 0;
      model_reset();
      clr_stats();

      // all four requesters valid, downstream always ready
      do_reset();
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_valid = 4'b1111;
      out_ready = 1'b1;
      clr_stats();
      repeat (10) tick();
      check("t29_n", 32'(q_ids.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         check("t29_id", 32'(q_ids[k]), 32'(k % NR));
         check("t29_data", 32'(q_dat[k]), 32'(8'hA0 + (k % NR)));
      end

      // single requester under backpressure
      do_reset();
      clr_stats();
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b0000;
      repeat (5) tick();
      out_ready = 1'b1;
      tick();
      tick();
      check("t30_rdy", 32'(rdy_cyc), 32'd1);
      check("t30_ov", 32'(ov_cyc), 32'd6);
      check("t30_id", 32'(q_ids[0]), 32'd2);

      // wrap-around from rr_ptr=3
      do_reset();
      clr_stats();
      out_ready = 1'b1;
      req_valid = 4'b0100;
      tick();
      tick();
      req_valid = 4'b0011;
      repeat (4) tick();
      check("t31_n", 32'(q_ids.size()), 32'd3);
      check("t31_g0", 32'(q_ids[0]), 32'd2);
      check("t31_g1", 32'(q_ids[1]), 32'd0);
      check("t31_g2", 32'(q_ids[2]), 32'd1);

      // asynchronous reset while holding a beat
      do_reset();
      req_data  = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
      req_valid = 4'b0001;
      out_ready = 1'b0;
      tick();
      check("t32_full", 32'(out_valid), 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check("t32_valid", 32'(out_valid), 32'd0);
      check("t32_data", 32'(out_data), 32'd0);
      check("t32_id", 32'(out_id), 32'd0);
      check("t32_rdy", 32'(req_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      #1;
      clr_stats();
      req_valid = 4'b1000;
      out_ready = 1'b1;
      repeat (2) tick();
      check("t32_n", 32'(q_ids.size()), 32'd1);
      check("t32_next", 32'(q_ids[0]), 32'd3);
      check("t32_ndata", 32'(q_dat[0]), 32'h5D);

      // random traffic with backpressure
      do_reset();
      max_wait = 0;
      for (int c = 0; c < 10000; c++) begin
         req_data  = $urandom;
         req_valid = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = '0;
      out_ready = 1'b1;
      repeat (4) tick();
      check("sb_empty", 32'(sb_id.size()), 32'd0);
      check("fair_max", 32'(max_wait <= NR - 1), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
